// File: rtl/fp_sub_seq.sv
// fp_sub_seq: multi-cycle binary64 subtractor (a - b), round-to-nearest-even,
// with valid/ready handshakes on operands and result. One operation in flight.
module fp_sub_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] diff
);

  localparam int unsigned MANT_W = 64;
  localparam int unsigned EXP_W  = 12;  // one spare bit above the 11-bit field for overflow detection
  localparam int unsigned FRAC_W = 52;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ALIGN = 3'd1;
  localparam logic [2:0] S_OP    = 3'd2;
  localparam logic [2:0] S_NORM  = 3'd3;
  localparam logic [2:0] S_ROUND = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [63:0]       a_q, a_d;
  logic [63:0]       b_q, b_d;         // subtrahend with its sign already inverted
  logic [MANT_W-1:0] mant_q, mant_d;   // big mantissa, later the working result
  logic [MANT_W-1:0] sml_q, sml_d;     // aligned small mantissa
  logic [EXP_W-1:0]  exp_q, exp_d;
  logic              sign_q, sign_d;
  logic              sub_q, sub_d;     // operand signs differ: magnitude subtract
  logic [63:0]       diff_q, diff_d;
  logic              out_valid_q, out_valid_d;
  logic              in_ready_q, in_ready_d;

  // Alignment signals
  logic [10:0]       exp_a, exp_b, big_e, sml_e, exp_gap;
  logic [MANT_W-1:0] man_a, man_b, big_m, sml_m, sml_sh;
  logic              a_big;

  // Add/subtract and rounding signals
  logic [MANT_W:0]   sum_ext;
  logic [MANT_W-1:0] dif_m;
  logic [10:0]       guard;
  logic              rnd_inc;
  logic [MANT_W:0]   rnd_sum;
  logic [MANT_W-1:0] rnd_mant;
  logic [EXP_W-1:0]  rnd_exp;

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign diff      = diff_q;

  // Operand ordering and right-shift alignment of the smaller mantissa
  always_comb begin
    exp_a   = a_q[62:52];
    exp_b   = b_q[62:52];
    man_a   = {1'b1, a_q[FRAC_W-1:0], 11'b0};
    man_b   = {1'b1, b_q[FRAC_W-1:0], 11'b0};
    a_big   = (exp_a > exp_b) || ((exp_a == exp_b) && (man_a >= man_b));
    big_e   = a_big ? exp_a : exp_b;
    sml_e   = a_big ? exp_b : exp_a;
    big_m   = a_big ? man_a : man_b;
    sml_m   = a_big ? man_b : man_a;
    exp_gap = big_e - sml_e;
    sml_sh  = (exp_gap >= 11'd64) ? '0 : (sml_m >> exp_gap[5:0]);
  end

  // Mantissa add/subtract and round-to-nearest-even datapath
  always_comb begin
    sum_ext  = {1'b0, mant_q} + {1'b0, sml_q};
    dif_m    = mant_q - sml_q;
    guard    = mant_q[10:0];
    rnd_inc  = (guard > 11'h400) || ((guard == 11'h400) && mant_q[11]);
    rnd_sum  = {1'b0, mant_q} + (rnd_inc ? 65'h800 : 65'd0);
    rnd_mant = rnd_sum[MANT_W] ? {1'b1, 63'b0} : rnd_sum[MANT_W-1:0];
    rnd_exp  = rnd_sum[MANT_W] ? exp_q + EXP_W'(1) : exp_q;
  end

  // Next-state and datapath update logic
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    mant_d      = mant_q;
    sml_d       = sml_q;
    exp_d       = exp_q;
    sign_d      = sign_q;
    sub_d       = sub_q;
    diff_d      = diff_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d        = a;
          b_d        = {~b[63], b[62:0]};
          in_ready_d = 1'b0;
          state_d    = S_ALIGN;
        end
      end
      S_ALIGN: begin
        mant_d  = big_m;
        sml_d   = sml_sh;
        exp_d   = EXP_W'(big_e);
        sign_d  = a_big ? a_q[63] : b_q[63];
        sub_d   = a_q[63] ^ b_q[63];
        state_d = S_OP;
      end
      S_OP: begin
        if (sub_q) begin
          mant_d = dif_m;
          if (dif_m == '0) begin
            // exact cancellation always yields +0
            sign_d = 1'b0;
            exp_d  = '0;
          end
        end else if (sum_ext[MANT_W]) begin
          mant_d = {1'b1, sum_ext[MANT_W-1:1]};
          exp_d  = exp_q + EXP_W'(1);
        end else begin
          mant_d = sum_ext[MANT_W-1:0];
        end
        state_d = S_NORM;
      end
      S_NORM: begin
        if (mant_q[MANT_W-1] || (mant_q == '0)) begin
          state_d = S_ROUND;
        end else if (exp_q == '0) begin
          // exponent exhausted before normalizing: flush to signed zero
          mant_d  = '0;
          state_d = S_ROUND;
        end else begin
          mant_d = {mant_q[MANT_W-2:0], 1'b0};
          exp_d  = exp_q - EXP_W'(1);
        end
      end
      S_ROUND: begin
        mant_d = rnd_mant;
        exp_d  = rnd_exp;
        if (rnd_exp >= EXP_W'(2047)) begin
          diff_d = {sign_q, 11'h7FF, 52'b0};
        end else begin
          diff_d = {sign_q, rnd_exp[10:0], rnd_mant[62:11]};
        end
        out_valid_d = 1'b1;
        state_d     = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = S_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      mant_q      <= '0;
      sml_q       <= '0;
      exp_q       <= '0;
      sign_q      <= 1'b0;
      sub_q       <= 1'b0;
      diff_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      mant_q      <= mant_d;
      sml_q       <= sml_d;
      exp_q       <= exp_d;
      sign_q      <= sign_d;
      sub_q       <= sub_d;
      diff_q      <= diff_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

endmodule

// File: tb/tb_fp_sub_seq.sv
// Testbench for fp_sub_seq: vector table, scoreboard queue, backpressure and mid-op reset.
module tb_fp_sub_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] a;
  logic [63:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] diff;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] d;
    int          lat;   // cycles from accept to out_valid, -1 = unchecked
  } vec_t;

  localparam int NVEC = 11;
  vec_t        vecs[NVEC];
  logic [63:0] sb_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  fp_sub_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Scoreboard: every completed handshake is matched against the oldest pending result
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_out: got diff %h with no pending operation", diff);
      end else begin
        check("diff", diff, sb_q.pop_front());
      end
    end
  end

  // Called #1 after a rising edge; returns #1 after the accept edge
  task automatic accept(input logic [63:0] av, input logic [63:0] bv, input logic [63:0] dv);
    int t;
    t = 0;
    while (!in_ready && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: in_ready got 0 expected 1");
    end
    a        = av;
    b        = bv;
    in_valid = 1'b1;
    sb_q.push_back(dv);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a        = {$urandom, $urandom};
    b        = {$urandom, $urandom};
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) begin
      n_checks++;
      n_fail++;
      $display("FAIL out_timeout: out_valid got 0 expected 1");
    end
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    accept(v.a, v.b, v.d);
    wait_out(lat);
    if (v.lat >= 0) check("latency", 64'(lat), 64'(v.lat));
    @(posedge clk); #1;
  endtask

  initial begin
    int   lat;
    int   ov_cnt;
    vec_t v;

    vecs[0]  = '{64'h4008000000000000, 64'h3FF0000000000000, 64'h4000000000000000, 4};  // 3 - 1
    vecs[1]  = '{64'h3FF8000000000000, 64'h3FF4000000000000, 64'h3FD0000000000000, 6};  // 1.5 - 1.25
    vecs[2]  = '{64'h3FF0000000000000, 64'h3FF0000000000000, 64'h0000000000000000, 4};  // 1 - 1
    vecs[3]  = '{64'h3FF0000000000000, 64'hBFF0000000000000, 64'h4000000000000000, 4};  // 1 - (-1)
    vecs[4]  = '{64'h3FF0000000000000, 64'hBCA0000000000000, 64'h3FF0000000000000, 4};  // tie, even
    vecs[5]  = '{64'h3FF0000000000000, 64'hBCA8000000000000, 64'h3FF0000000000001, 4};  // above half
    vecs[6]  = '{64'h4000000000000000, 64'h3FF0000000000000, 64'h3FF0000000000000, 5};  // 2 - 1
    vecs[7]  = '{64'hBFF0000000000000, 64'h3FF0000000000000, 64'hC000000000000000, 4};  // -1 - 1
    vecs[8]  = '{64'h3FF0000000000000, 64'h4000000000000000, 64'hBFF0000000000000, 5};  // 1 - 2
    vecs[9]  = '{64'h7FEFFFFFFFFFFFFF, 64'hFFEFFFFFFFFFFFFF, 64'h7FF0000000000000, 4};  // overflow
    vecs[10] = '{64'h3FF0000000000000, 64'h39B0000000000000, 64'h3FF0000000000000, 4};  // gap >= 64

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_diff", diff, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < NVEC; i++) run_vec(vecs[i]);

    // Backpressure: result held while out_ready is low
    out_ready = 1'b0;
    accept(vecs[0].a, vecs[0].b, vecs[0].d);
    wait_out(lat);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_diff", diff, 64'h4000000000000000);
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_in_ready", 64'(in_ready), 64'd1);
    check("bp_release_out_valid", 64'(out_valid), 64'd0);
    run_vec(vecs[1]);
    run_vec(vecs[5]);

    // Reset asserted while 1.5 - 1.25 is normalizing
    accept(vecs[1].a, vecs[1].b, vecs[1].d);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    check("mid_rst_diff", diff, 64'd0);
    sb_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    ov_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) ov_cnt++;
      @(posedge clk); #1;
    end
    check("post_rst_no_out_valid", 64'(ov_cnt), 64'd0);
    v = vecs[0];
    run_vec(v);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
